run_controller: RTL
===================

Name: run_controller

Overview:
- Synthesizable, parametrised run-control block that sequences core bring-up.
- Holds downstream resets for a programmable count, then releases NUM_CHAN reset channels staggered in time.
- Runs the core until it halts or a cycle limit expires, then drains and re-asserts the resets.
- Sits between the board/bench reset and vlsiwCore instances; gives benches and silicon one common start/finish mechanism.

Parameters:
- NUM_CHAN, 4: number of independent active-low reset outputs released in order 0..NUM_CHAN-1.
- CNT_W, 16: width of hold, limit and cycle counters.
- STAGGER, 2: cycles between successive channel releases; STAGGER>=1.
- DRAIN_CYCLES, 2: cycles spent in DRAIN after halt or timeout, before resets re-assert.

Ports:
- clock, in, 1: single clock; all state updates on posedge.
- reset, in, 1: synchronous, active-low block reset.
- start, in, 1: begin a run; sampled only in IDLE or DONE.
- cfg_hold, in, CNT_W: hold-cycle count, latched on an accepted start; 0 is treated as 1.
- cfg_limit, in, CNT_W: run cycle limit, latched on an accepted start; 0 means unlimited.
- halt_req, in, 1: core requests finish; honoured only in RUN.
- core_reset_n, out, NUM_CHAN: registered active-low resets to the core(s).
- running, out, 1: high while in RUN.
- done, out, 1: sticky completion flag.
- timeout, out, 1: sticky; set when the run ended by reaching the limit.
- cycle_count, out, CNT_W: RUN cycles elapsed; saturates at all-ones.

Behaviour:
- reset low at a posedge:
  - state becomes IDLE.
  - core_reset_n=0, running=0, done=0, timeout=0, cycle_count=0.
  - Latched cfg values are cleared.
  - Applies mid-operation too, with no partial release.
- States: IDLE, HOLD, RELEASE, RUN, DRAIN, DONE. Every output is a register; no combinational path from inputs to outputs.
- IDLE:
  - start=1 latches cfg_hold/cfg_limit and moves to HOLD with the internal counter at 0.
- HOLD:
  - All resets stay asserted.
  - After cfg_hold cycles, move to RELEASE.
  - At the same edge, core_reset_n[0] goes 1.
- RELEASE:
  - Channel i goes 1 exactly i*STAGGER cycles after channel 0.
  - When the last channel goes 1, move to RUN at that same edge.
  - With NUM_CHAN=1, HOLD goes straight to RUN.
- RUN:
  - running=1.
  - cycle_count is 0 in the first RUN cycle and increments by 1 each cycle.
  - halt_req=1: go to DRAIN with timeout=0.
  - Otherwise, if cfg_limit!=0 and cycle_count==cfg_limit-1: go to DRAIN with timeout=1.
  - halt_req and the limit in the same cycle: halt wins, timeout stays 0.
- DRAIN:
  - running=0, resets still released, cycle_count frozen.
  - After DRAIN_CYCLES cycles: all core_reset_n go to 0, done goes to 1, move to DONE.
- DONE:
  - done, timeout and cycle_count hold.
  - start=1 clears done, timeout and cycle_count, re-latches cfg, and goes to HOLD.
- start outside IDLE/DONE is ignored. halt_req outside RUN is ignored.

Optional Feature:
- Macro: RUN_CONTROLLER_WATCHDOG_EN.
- With the macro defined:
  - Adds input heartbeat (1 bit) and parameter WDOG_CYCLES (default 1024).
  - In RUN, a watchdog counter resets on heartbeat=1 or on entry to RUN, and otherwise increments.
  - When it reaches WDOG_CYCLES-1: go to DRAIN with timeout=1.
  - Priority: halt_req > watchdog > limit.
- Without the macro: no heartbeat port, no watchdog logic; behaviour is exactly as specified above.

Decomposition:
- Package run_controller_pkg holds:
  - state enum run_state_t.
  - CNT_W default.
  - Helper constant for RELEASE length, (NUM_CHAN-1)*STAGGER.
- Sub-module run_controller_stagger: shift/counter that releases NUM_CHAN channels at STAGGER spacing, with enable and clear inputs. The top-level FSM owns all other counters.

Test Plan:
Defaults assumed: NUM_CHAN=4, STAGGER=2, DRAIN_CYCLES=2.
- reset low for 3 cycles, then high; start idle for 10 cycles -> core_reset_n=4'b0000, running=0, done=0 throughout.
- start pulse at edge T with cfg_hold=50, cfg_limit=0 -> core_reset_n bit0 rises at T+50, bit1 at T+52, bit2 at T+54, bit3 at T+56; running=1 from T+56.
- halt_req at RUN cycle 20 -> cycle_count=20 frozen, running=0; two cycles later core_reset_n=0, done=1, timeout=0.
- cfg_limit=8, no halt -> RUN lasts 8 cycles, cycle_count=7, timeout=1, done=1; halt_req together with the limit cycle -> timeout=0.
- reset low during RELEASE (two channels released) -> next cycle all four channels 0, state IDLE; a start issued while in RUN is ignored (no counter restart).
- With RUN_CONTROLLER_WATCHDOG_EN, WDOG_CYCLES=16, heartbeat stopped -> timeout=1 after 16 RUN cycles without heartbeat; heartbeat every 10 cycles -> no timeout.

Source files
------------

// File: rtl/run_controller_pkg.sv
// Shared types and helpers for the run_controller bring-up sequencer.
package run_controller_pkg;

   localparam int CNT_W_DEF = 16;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HOLD    = 3'd1,
      ST_RELEASE = 3'd2,
      ST_RUN     = 3'd3,
      ST_DRAIN   = 3'd4,
      ST_DONE    = 3'd5
   } run_state_t;

   // Cycles between channel 0 release and last channel release.
   function automatic int release_len(input int num_chan, input int stagger);
      return (num_chan - 1) * stagger;
   endfunction

endpackage

// File: rtl/run_controller_stagger.sv
// Staggered release of NUM_CHAN active-low resets: the first enabled edge frees
// channel 0, then one more channel every STAGGER enabled edges.
module run_controller_stagger #(
   parameter int NUM_CHAN = 4,
   parameter int STAGGER  = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic                clear,
   output logic [NUM_CHAN-1:0] released
);

   localparam int SW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
   localparam logic [SW-1:0]       GAP_LAST  = SW'(STAGGER - 1);
   localparam logic [SW-1:0]       GAP_ZERO  = {SW{1'b0}};
   localparam logic [SW-1:0]       GAP_ONE   = SW'(1'b1);
   localparam logic [NUM_CHAN-1:0] REL_NONE  = {NUM_CHAN{1'b0}};
   localparam logic [NUM_CHAN-1:0] REL_FIRST = NUM_CHAN'(1'b1);

   logic [SW-1:0]       gap_cnt_r;
   logic [NUM_CHAN-1:0] rel_r;

   // Release vector fills from bit 0 upward, spaced by the gap counter.
   always_ff @(posedge clock) begin
      if (!reset || clear) begin
         rel_r     <= REL_NONE;
         gap_cnt_r <= GAP_ZERO;
      end else if (enable) begin
         if (rel_r == REL_NONE) begin
            rel_r     <= REL_FIRST;
            gap_cnt_r <= GAP_ZERO;
         end else if (&rel_r) begin
            rel_r     <= rel_r;
            gap_cnt_r <= GAP_ZERO;
         end else if (gap_cnt_r == GAP_LAST) begin
            rel_r     <= (rel_r << 1) | REL_FIRST;
            gap_cnt_r <= GAP_ZERO;
         end else begin
            gap_cnt_r <= gap_cnt_r + GAP_ONE;
         end
      end else begin
         rel_r     <= rel_r;
         gap_cnt_r <= gap_cnt_r;
      end
   end

   assign released = rel_r;

endmodule

// File: rtl/run_controller.sv
// Run-control sequencer: hold resets, staggered release, run until halt/limit, drain.
// Optional watchdog on a heartbeat input when RUN_CONTROLLER_WATCHDOG_EN is defined.
module run_controller
   import run_controller_pkg::*;
#(
   parameter int NUM_CHAN     = 4,
   parameter int CNT_W        = CNT_W_DEF,
   parameter int STAGGER      = 2,
   parameter int DRAIN_CYCLES = 2
`ifdef RUN_CONTROLLER_WATCHDOG_EN
   ,parameter int WDOG_CYCLES = 1024
`endif
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic [CNT_W-1:0]    cfg_hold,
   input  logic [CNT_W-1:0]    cfg_limit,
   input  logic                halt_req,
`ifdef RUN_CONTROLLER_WATCHDOG_EN
   input  logic                heartbeat,
`endif
   output logic [NUM_CHAN-1:0] core_reset_n,
   output logic                running,
   output logic                done,
   output logic                timeout,
   output logic [CNT_W-1:0]    cycle_count
);

   localparam int REL_LEN  = release_len(NUM_CHAN, STAGGER);
   localparam int REL_LAST = (REL_LEN > 0) ? REL_LEN - 1 : 0;
   localparam logic [CNT_W-1:0] ZERO       = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE        = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0] ONES       = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] REL_END    = CNT_W'(REL_LAST);
   localparam logic [CNT_W-1:0] DRAIN_END  = CNT_W'(DRAIN_CYCLES - 1);

   run_state_t       state_r;
   logic [CNT_W-1:0] hold_r;
   logic [CNT_W-1:0] limit_r;
   logic [CNT_W-1:0] phase_cnt_r;
   logic [CNT_W-1:0] cycle_count_r;
   logic             running_r;
   logic             done_r;
   logic             timeout_r;

   logic [CNT_W-1:0] hold_last_s;
   logic             hold_done_s;
   logic             drain_done_s;
   logic             limit_hit_s;
   logic             wdog_trip_s;
   logic             stagger_en_s;
   logic             stagger_clr_s;

   // A zero hold behaves like a one-cycle hold.
   assign hold_last_s  = (hold_r == ZERO) ? ZERO : hold_r - ONE;
   assign hold_done_s  = (phase_cnt_r == hold_last_s);
   assign drain_done_s = (phase_cnt_r == DRAIN_END);
   assign limit_hit_s  = (limit_r != ZERO) && (cycle_count_r == limit_r - ONE);

`ifdef RUN_CONTROLLER_WATCHDOG_EN
   logic [31:0] wdog_cnt_r;

   // Watchdog restarts on every heartbeat and whenever the core is not running.
   always_ff @(posedge clock) begin
      if (!reset) begin
         wdog_cnt_r <= 32'd0;
      end else if ((state_r != ST_RUN) || heartbeat) begin
         wdog_cnt_r <= 32'd0;
      end else begin
         wdog_cnt_r <= wdog_cnt_r + 32'd1;
      end
   end

   assign wdog_trip_s = !heartbeat && (wdog_cnt_r == 32'(WDOG_CYCLES - 1));
`else
   assign wdog_trip_s = 1'b0;
`endif

   // Stagger advances from the final HOLD edge through RELEASE; emptied at drain end.
   always_comb begin
      stagger_en_s  = 1'b0;
      stagger_clr_s = 1'b0;
      case (state_r)
         ST_HOLD:    stagger_en_s  = hold_done_s;
         ST_RELEASE: stagger_en_s  = 1'b1;
         ST_DRAIN:   stagger_clr_s = drain_done_s;
         ST_IDLE:    stagger_clr_s = 1'b1;
         ST_DONE:    stagger_clr_s = 1'b1;
         default:    stagger_clr_s = 1'b0;
      endcase
   end

   run_controller_stagger #(
      .NUM_CHAN (NUM_CHAN),
      .STAGGER  (STAGGER)
   ) u_stagger (
      .clock    (clock),
      .reset    (reset),
      .enable   (stagger_en_s),
      .clear    (stagger_clr_s),
      .released (core_reset_n)
   );

   // Main sequencing FSM with its counters and registered status outputs.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_r       <= ST_IDLE;
         hold_r        <= ZERO;
         limit_r       <= ZERO;
         phase_cnt_r   <= ZERO;
         cycle_count_r <= ZERO;
         running_r     <= 1'b0;
         done_r        <= 1'b0;
         timeout_r     <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  hold_r        <= cfg_hold;
                  limit_r       <= cfg_limit;
                  phase_cnt_r   <= ZERO;
                  cycle_count_r <= ZERO;
                  done_r        <= 1'b0;
                  timeout_r     <= 1'b0;
                  state_r       <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (hold_done_s) begin
                  phase_cnt_r <= ZERO;
                  if (NUM_CHAN == 1) begin
                     running_r <= 1'b1;
                     state_r   <= ST_RUN;
                  end else begin
                     state_r   <= ST_RELEASE;
                  end
               end else begin
                  phase_cnt_r <= phase_cnt_r + ONE;
               end
            end
            ST_RELEASE: begin
               if (phase_cnt_r == REL_END) begin
                  phase_cnt_r <= ZERO;
                  running_r   <= 1'b1;
                  state_r     <= ST_RUN;
               end else begin
                  phase_cnt_r <= phase_cnt_r + ONE;
               end
            end
            ST_RUN: begin
               if (halt_req) begin
                  phase_cnt_r <= ZERO;
                  running_r   <= 1'b0;
                  timeout_r   <= 1'b0;
                  state_r     <= ST_DRAIN;
               end else if (wdog_trip_s || limit_hit_s) begin
                  phase_cnt_r <= ZERO;
                  running_r   <= 1'b0;
                  timeout_r   <= 1'b1;
                  state_r     <= ST_DRAIN;
               end else if (cycle_count_r != ONES) begin
                  cycle_count_r <= cycle_count_r + ONE;
               end
            end
            ST_DRAIN: begin
               if (drain_done_s) begin
                  phase_cnt_r <= ZERO;
                  done_r      <= 1'b1;
                  state_r     <= ST_DONE;
               end else begin
                  phase_cnt_r <= phase_cnt_r + ONE;
               end
            end
            default: begin
               running_r <= 1'b0;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

   assign running     = running_r;
   assign done        = done_r;
   assign timeout     = timeout_r;
   assign cycle_count = cycle_count_r;

endmodule
